toggle_pulse_rx: RTL and testbench

- Receiving end of a toggle-encoded event line: the transmitter flips one level per event, as a T flip-flop driven by t=1 for one cycle does.
- This block synchronises that line and converts each level change back into a single-cycle pulse.
- It also keeps a saturating event count, a pending flag with ack handshake, and a sticky overflow flag.
- It sits between a toggle source (possibly asynchronous) and local control logic.

---
 rtl/toggle_pulse_rx_pkg.sv | 6 +
 rtl/toggle_pulse_rx_sync_chain.sv | 16 +
 rtl/toggle_pulse_rx.sv | 65 ++++++
 tb/tb_toggle_pulse_rx.sv | 134 +++++++++++++
 4 files changed

// File: rtl/toggle_pulse_rx_pkg.sv
// toggle_pulse_rx_pkg: receiver FSM state encoding and default parameters
package toggle_pulse_rx_pkg;
  typedef enum logic {ST_ARM, ST_RUN} state_e;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int CNT_W_DEF = 8;
endpackage

// File: rtl/toggle_pulse_rx_sync_chain.sv
// toggle_pulse_rx_sync_chain: SYNC_STAGES-deep synchroniser with async active-low reset
module toggle_pulse_rx_sync_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);
  logic [SYNC_STAGES-1:0] stg_q, stg_d;
  always_comb stg_d = {stg_q[SYNC_STAGES-2:0], din};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) stg_q <= '0;
    else stg_q <= stg_d;
  assign dout = stg_q[SYNC_STAGES-1];
endmodule

// File: rtl/toggle_pulse_rx.sv
// toggle_pulse_rx: turns each level change on a toggle line into one pulse,
// with saturating event count, ack handshake and sticky overflow.
module toggle_pulse_rx
  import toggle_pulse_rx_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             c,
  input  logic             rst,
  input  logic             tin,
  input  logic             ack,
  input  logic             clr,
  output logic             level,
  output logic             pulse,
  output logic             pend,
  output logic             ovf,
  output logic [CNT_W-1:0] evt_cnt
);
  localparam int ARM_W = $clog2(SYNC_STAGES + 2);
  state_e state_q, state_d;
  logic [ARM_W-1:0] arm_q, arm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic prev_q, prev_d, pulse_q, pulse_d, pend_q, pend_d, ovf_q, ovf_d, edge_w;
  toggle_pulse_rx_sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk  (c),
    .rst_n(rst),
    .din  (tin),
    .dout (level)
  );
  // ARM lets the synchroniser fill so the level held at release becomes the baseline
  always_comb begin
    edge_w  = (state_q == ST_RUN) && (level ^ prev_q);
    state_d = (state_q == ST_ARM && arm_q == ARM_W'(SYNC_STAGES)) ? ST_RUN : state_q;
    arm_d   = (state_q == ST_ARM) ? arm_q + 1'b1 : arm_q;
    prev_d  = level;
    pulse_d = edge_w;
    cnt_d   = clr ? CNT_W'(edge_w) : (edge_w && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    pend_d  = edge_w || (pend_q && !ack);
    ovf_d   = (edge_w && pend_q && !ack) || (ovf_q && !clr);
  end
  always_ff @(posedge c or negedge rst) begin
    if (!rst) begin
      state_q <= ST_ARM;
      arm_q   <= '0;
      cnt_q   <= '0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
      pend_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      arm_q   <= arm_d;
      cnt_q   <= cnt_d;
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end
  assign pulse   = pulse_q;
  assign pend    = pend_q;
  assign ovf     = ovf_q;
  assign evt_cnt = cnt_q;
endmodule

// File: tb/tb_toggle_pulse_rx.sv
// tb_toggle_pulse_rx: directed toggles with a pulse scoreboard, SYNC_STAGES=2, CNT_W=3
module tb_toggle_pulse_rx;
  logic c = 1'b0, rst = 1'b0, tin = 1'b1, ack = 1'b0, clr = 1'b0;
  logic level, pulse, pend, ovf;
  logic [2:0] evt_cnt;
  int checks = 0, errors = 0, cyc = 0;
  typedef struct {
    int         cyc;
    logic [2:0] cnt;
    logic       ovf;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  toggle_pulse_rx #(.SYNC_STAGES(2), .CNT_W(3)) dut (
    .c(c), .rst(rst), .tin(tin), .ack(ack), .clr(clr),
    .level(level), .pulse(pulse), .pend(pend), .ovf(ovf), .evt_cnt(evt_cnt)
  );

  initial forever #5 c = ~c;
  always @(posedge c) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge c);
  endtask

  // tin flips at a negedge; the pulse is visible three negedges later
  task automatic toggle(input logic [2:0] ecnt, input logic eovf, input int hold,
                        input logic mid_ack, input logic mid_clr);
    tin = ~tin;
    sb.push_back('{cyc + 3, ecnt, eovf});
    step(2);
    ack = mid_ack;
    clr = mid_clr;
    step(1);
    ack = 1'b0;
    clr = 1'b0;
    step(hold - 3);
  endtask

  always @(negedge c) begin
    if (pulse) begin
      if (sb.size() == 0) chk("unexpected_pulse", 1, 0);
      else begin
        e = sb.pop_front();
        chk("pulse_cycle", cyc, e.cyc);
        chk("pulse_cnt", evt_cnt, e.cnt);
        chk("pulse_pend", pend, 1);
        chk("pulse_ovf", ovf, e.ovf);
      end
    end
  end

  initial begin
    step(2);
    chk("rst_level", level, 0);
    chk("rst_pulse", pulse, 0);
    chk("rst_pend", pend, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_cnt", evt_cnt, 0);
    rst = 1'b1;
    step(1);
    chk("sync_lvl_e1", level, 0);
    step(1);
    chk("sync_lvl_e2", level, 1);
    step(8);
    chk("base_cnt", evt_cnt, 0);
    chk("base_pend", pend, 0);
    // two clean toggles, each acked
    toggle(3'd1, 1'b0, 6, 1'b0, 1'b0);
    ack = 1'b1; step(1); ack = 1'b0;
    chk("ack1_pend", pend, 0);
    toggle(3'd2, 1'b0, 6, 1'b0, 1'b0);
    chk("two_cnt", evt_cnt, 2);
    ack = 1'b1; step(1); ack = 1'b0;
    chk("ack2_pend", pend, 0);
    clr = 1'b1; step(1); clr = 1'b0;
    chk("clr_cnt", evt_cnt, 0);
    // overflow: second event while still pending
    toggle(3'd1, 1'b0, 5, 1'b0, 1'b0);
    toggle(3'd2, 1'b1, 6, 1'b0, 1'b0);
    chk("ovf_set", ovf, 1);
    chk("ovf_pend", pend, 1);
    chk("ovf_cnt", evt_cnt, 2);
    ack = 1'b1; step(1); ack = 1'b0;
    chk("ovf_ack_pend", pend, 0);
    step(2);
    chk("ovf_sticky", ovf, 1);
    clr = 1'b1; step(1); clr = 1'b0;
    chk("ovf_clr", ovf, 0);
    chk("ovf_clr_cnt", evt_cnt, 0);
    // ack coincident with a new edge: event wins, no overflow
    toggle(3'd1, 1'b0, 6, 1'b0, 1'b0);
    toggle(3'd2, 1'b0, 6, 1'b1, 1'b0);
    chk("ackedge_pend", pend, 1);
    chk("ackedge_ovf", ovf, 0);
    // saturation at 7, then clr together with an overflowing edge
    ack = 1'b1; step(1); ack = 1'b0;
    clr = 1'b1; step(1); clr = 1'b0;
    chk("sat_pre_pend", pend, 0);
    for (int i = 1; i <= 9; i++) toggle((i < 7) ? 3'(i) : 3'd7, i >= 2, 3, 1'b0, 1'b0);
    chk("sat_cnt", evt_cnt, 7);
    toggle(3'd1, 1'b1, 6, 1'b0, 1'b1);
    chk("clredge_cnt", evt_cnt, 1);
    chk("clredge_ovf", ovf, 1);
    // reset with a toggle in flight
    tin = ~tin;
    step(1);
    rst = 1'b0;
    #1;
    chk("arst_level", level, 0);
    chk("arst_pulse", pulse, 0);
    chk("arst_pend", pend, 0);
    chk("arst_ovf", ovf, 0);
    chk("arst_cnt", evt_cnt, 0);
    step(2);
    rst = 1'b1;
    step(12);
    chk("post_rst_cnt", evt_cnt, 0);
    chk("post_rst_pend", pend, 0);
    chk("post_rst_level", level, tin);
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
